// File: rtl/uv_scan_doubler.sv
// Line-rate doubler: captures each UV line into a ping-pong buffer and replays it twice at out_ce rate.
// Optional SCANLINE_DIM_EN: halves luma on the second replay of each line.
module uv_scan_doubler #(
  parameter int unsigned LINE_W   = 320,
  parameter int unsigned COL_W    = 9,
  parameter int unsigned H_TOTAL  = 454,
  parameter int unsigned HS_START = 336,
  parameter int unsigned HS_END   = 384
) (
  input  logic       sysclk,
  input  logic       reset_b,
  input  logic       in_ce,
  input  logic [7:0] uv_in,
  input  logic       in_hblank,
  input  logic       in_vblank,
  input  logic       in_vsync,
  input  logic       out_ce,
  output logic [7:0] uv_out,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       out_hblank,
  output logic       out_vblank,
  output logic       overrun,
  output logic       truncated
);

  localparam logic [COL_W-1:0] LW_C      = COL_W'(LINE_W);
  localparam logic [COL_W-1:0] HT_LAST_C = COL_W'(H_TOTAL - 1);
  localparam logic [COL_W-1:0] HSS_C     = COL_W'(HS_START);
  localparam logic [COL_W-1:0] HSE_C     = COL_W'(HS_END);

  typedef enum logic [1:0] {IDLE, REP0, REP1} state_t;

  state_t           state_q;
  logic [7:0]       mem0 [LINE_W];
  logic [7:0]       mem1 [LINE_W];
  logic [7:0]       rdata_q;
  logic             wbank_q, rbank_q, ready_bank_q, pending_q, hb_prev_q;
  logic [COL_W-1:0] wcol_q, h_cnt_q, h_cnt_d;
  logic [COL_W-1:0] line_len_q [2];

  logic             capture, wr_en, eol, wrap, take, rbank_d, blank;
  logic [7:0]       pix;

  always_comb begin
    capture = in_ce & ~in_hblank & ~in_vblank;
    wr_en   = capture & (wcol_q != LW_C);
    eol     = in_ce & in_hblank & ~hb_prev_q & ~in_vblank & (wcol_q != '0);
    wrap    = out_ce & (h_cnt_q == HT_LAST_C);
    h_cnt_d = h_cnt_q;
    if (out_ce) h_cnt_d = wrap ? '0 : h_cnt_q + COL_W'(1);
    take    = wrap & pending_q & (state_q != REP0);
    rbank_d = take ? ready_bank_q : rbank_q;
    blank   = (h_cnt_q >= LW_C) | (state_q == IDLE);
    pix     = (!blank && (h_cnt_q < line_len_q[rbank_q])) ? rdata_q : '0;
`ifdef SCANLINE_DIM_EN
    if (state_q == REP1) pix = {pix[7:4], 1'b0, pix[3:1]};
`endif
  end

  // Read address uses the column that becomes current at this edge, so the
  // registered RAM word is ready when the output stage consumes h_cnt_q.
  always_ff @(posedge sysclk) begin
    if (wr_en) begin
      if (wbank_q) mem1[wcol_q] <= uv_in;
      else         mem0[wcol_q] <= uv_in;
    end
    if (h_cnt_d < LW_C) rdata_q <= rbank_d ? mem1[h_cnt_d] : mem0[h_cnt_d];
  end

  always_ff @(posedge sysclk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= IDLE;
      wbank_q       <= 1'b0;
      rbank_q       <= 1'b0;
      ready_bank_q  <= 1'b0;
      pending_q     <= 1'b0;
      hb_prev_q     <= 1'b1;
      wcol_q        <= '0;
      h_cnt_q       <= '0;
      line_len_q[0] <= '0;
      line_len_q[1] <= '0;
      uv_out        <= '0;
      out_hsync     <= 1'b0;
      out_vsync     <= 1'b0;
      out_hblank    <= 1'b1;
      out_vblank    <= 1'b1;
      overrun       <= 1'b0;
      truncated     <= 1'b0;
    end else begin
      if (in_ce)   hb_prev_q <= in_hblank;
      if (wr_en)   wcol_q    <= wcol_q + COL_W'(1);
      if (capture && (wcol_q == LW_C)) truncated <= 1'b1;

      if (eol) begin
        line_len_q[wbank_q] <= wcol_q;
        ready_bank_q        <= wbank_q;
        wbank_q             <= ~wbank_q;
        wcol_q              <= '0;
        if (pending_q) overrun <= 1'b1;
      end

      if (eol)       pending_q <= 1'b1;
      else if (take) pending_q <= 1'b0;

      h_cnt_q <= h_cnt_d;

      if (wrap) begin
        rbank_q    <= rbank_d;
        out_vsync  <= in_vsync;
        out_vblank <= in_vblank;
        case (state_q)
          IDLE:    state_q <= pending_q ? REP0 : IDLE;
          REP0:    state_q <= REP1;
          REP1:    state_q <= pending_q ? REP0 : IDLE;
          default: state_q <= IDLE;
        endcase
      end

      if (out_ce) begin
        uv_out     <= pix;
        out_hblank <= blank;
        out_hsync  <= (h_cnt_q >= HSS_C) && (h_cnt_q < HSE_C);
      end
    end
  end

endmodule
